// File: rtl/score_pkg.sv
// Shared types and default constants for the score keeper.
//   state_t           : score keeper FSM states
//   DEF_SCORE_W       : default width of score, length and high score
//   DEF_NDIG          : default number of BCD display digits
//   DEF_MAX_SCORE     : default winning score
//   DEF_HOLD_TICKS    : default number of ticks the final score flashes
package score_pkg;

    typedef enum logic [1:0] {
        ST_PLAY      = 2'd0,
        ST_HOLD      = 2'd1,
        ST_SHOW_HIGH = 2'd2
    } state_t;

    localparam int DEF_SCORE_W    = 7;
    localparam int DEF_NDIG       = 2;
    localparam int DEF_MAX_SCORE  = 50;
    localparam int DEF_HOLD_TICKS = 6;

endpackage

// File: rtl/score_bcd_counter.sv
// Multi-digit BCD register with synchronous clear, parallel load and
// digit-wise increment (9 rolls to 0 and carries into the next digit).
//   clk, nRst   : clock, asynchronous active-low reset
//   i_clr       : synchronous clear (highest priority)
//   i_load      : load i_load_val
//   i_inc       : increment by one (lowest priority)
//   i_load_val  : parallel load value
//   o_bcd       : registered BCD value, digit 0 in bits [3:0]
//   o_inc_val   : combinational value o_bcd + 1, used for look-ahead
module score_bcd_counter
    import score_pkg::*;
#(
    parameter int NDIG = DEF_NDIG
) (
    input  logic              clk,
    input  logic              nRst,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic              i_inc,
    input  logic [4*NDIG-1:0] i_load_val,
    output logic [4*NDIG-1:0] o_bcd,
    output logic [4*NDIG-1:0] o_inc_val
);

    logic [4*NDIG-1:0] r_bcd;
    logic [4*NDIG-1:0] w_inc;

    // Ripple the carry digit by digit; a digit only changes while the carry
    // from all lower digits is still set.
    always_comb begin
        logic carry;
        w_inc = r_bcd;
        carry = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            if (carry) begin
                if (r_bcd[4*d +: 4] == 4'd9) begin
                    w_inc[4*d +: 4] = 4'd0;
                end else begin
                    w_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_bcd <= '0;
        end else if (i_clr) begin
            r_bcd <= '0;
        end else if (i_load) begin
            r_bcd <= i_load_val;
        end else if (i_inc) begin
            r_bcd <= w_inc;
        end
    end

    assign o_bcd     = r_bcd;
    assign o_inc_val = w_inc;

endmodule

// File: rtl/score_keeper.sv
// Snake game score keeper: counts food, ends the game on a fatal collision
// or on reaching the winning score, flashes the final score for a number of
// ticks and then shows the best score until a new game is started.
//   clk, nRst   : clock, asynchronous active-low reset
//   tick        : slow timebase strobe (flash / hold timing)
//   good_coll   : food eaten strobe
//   bad_coll    : fatal collision strobe
//   start       : new game strobe
//   length      : snake length (equals current score)
//   bcd         : displayed value in BCD, digit 0 in bits [3:0]
//   blank       : 1 blanks the display digits
//   high_score  : best score since reset
//   game_over   : high whenever not playing
//   new_high    : last finished game set a new high score
//
// state        | meaning
// -------------+-----------------------------------------------
// ST_PLAY      | game running, collisions counted
// ST_HOLD      | game ended, final score flashing on ticks
// ST_SHOW_HIGH | high score displayed, waiting for start
module score_keeper
    import score_pkg::*;
#(
    parameter int SCORE_W    = DEF_SCORE_W,
    parameter int NDIG       = DEF_NDIG,
    parameter int MAX_SCORE  = DEF_MAX_SCORE,
    parameter int HOLD_TICKS = DEF_HOLD_TICKS
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               tick,
    input  logic               good_coll,
    input  logic               bad_coll,
    input  logic               start,
    output logic [SCORE_W-1:0] length,
    output logic [4*NDIG-1:0]  bcd,
    output logic               blank,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_over,
    output logic               new_high
);

    if (MAX_SCORE >= 10**NDIG || MAX_SCORE >= 2**SCORE_W || HOLD_TICKS < 1) begin : g_bad_params
        $error("score_keeper: MAX_SCORE must fit NDIG digits and SCORE_W bits, HOLD_TICKS must be >= 1");
    end

    localparam int HCNT_W = (HOLD_TICKS < 2) ? 1 : $clog2(HOLD_TICKS + 1);
    localparam logic [SCORE_W-1:0] MAX_V     = SCORE_W'(MAX_SCORE);
    localparam logic [HCNT_W-1:0]  HOLD_INIT = HCNT_W'(HOLD_TICKS);

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_high;
    logic [4*NDIG-1:0]  r_high_bcd;
    logic [HCNT_W-1:0]  r_hold_cnt;
    logic               r_blank;
    logic               r_game_over;
    logic               r_new_high;

    logic [SCORE_W-1:0] w_score_inc;
    logic               w_good;
    logic               w_end;
    logic [SCORE_W-1:0] w_final;
    logic [4*NDIG-1:0]  w_bcd_cur;
    logic [4*NDIG-1:0]  w_bcd_inc;
    logic [4*NDIG-1:0]  w_final_bcd;
    logic               w_bcd_clr;
    logic               w_bcd_load;
    logic               w_hold_last;

    assign w_score_inc = r_score + 1'b1;
    // bad_coll wins over good_coll in the same cycle
    assign w_good      = (r_state == ST_PLAY) && good_coll && !bad_coll;
    assign w_end       = (r_state == ST_PLAY) && (bad_coll || (good_coll && (w_score_inc == MAX_V)));
    // When the winning pellet ends the game, the final value is the
    // incremented one, so the high shadow takes the look-ahead BCD.
    assign w_final     = bad_coll ? r_score   : w_score_inc;
    assign w_final_bcd = bad_coll ? w_bcd_cur : w_bcd_inc;
    assign w_hold_last = (r_state == ST_HOLD) && tick && (r_hold_cnt == HCNT_W'(1));
    assign w_bcd_clr   = (r_state == ST_SHOW_HIGH) && start;
    assign w_bcd_load  = w_hold_last;

    score_bcd_counter #(
        .NDIG (NDIG)
    ) u_bcd (
        .clk        (clk),
        .nRst       (nRst),
        .i_clr      (w_bcd_clr),
        .i_load     (w_bcd_load),
        .i_inc      (w_good),
        .i_load_val (r_high_bcd),
        .o_bcd      (w_bcd_cur),
        .o_inc_val  (w_bcd_inc)
    );

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state     <= ST_PLAY;
            r_score     <= '0;
            r_high      <= '0;
            r_high_bcd  <= '0;
            r_hold_cnt  <= '0;
            r_blank     <= 1'b0;
            r_game_over <= 1'b0;
            r_new_high  <= 1'b0;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (w_good) begin
                        r_score <= w_score_inc;
                    end
                    if (w_end) begin
                        if (w_final > r_high) begin
                            r_high     <= w_final;
                            r_high_bcd <= w_final_bcd;
                            r_new_high <= 1'b1;
                        end else begin
                            r_new_high <= 1'b0;
                        end
                        r_hold_cnt  <= HOLD_INIT;
                        r_game_over <= 1'b1;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        if (w_hold_last) begin
                            r_blank <= 1'b0;
                            r_state <= ST_SHOW_HIGH;
                        end else begin
                            r_blank <= ~r_blank;
                        end
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                ST_SHOW_HIGH: begin
                    if (start) begin
                        r_score     <= '0;
                        r_blank     <= 1'b0;
                        r_game_over <= 1'b0;
                        r_new_high  <= 1'b0;
                        r_state     <= ST_PLAY;
                    end
                end
                default: begin
                    r_state <= ST_PLAY;
                end
            endcase
        end
    end

    assign length     = r_score;
    assign bcd        = w_bcd_cur;
    assign blank      = r_blank;
    assign high_score = r_high;
    assign game_over  = r_game_over;
    assign new_high   = r_new_high;

endmodule
